// File: rtl/score_counter_pkg.sv
// Shared game definitions: FSM state encoding and BCD score limits.
package score_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam logic [3:0] SCORE_OVF = 4'd10;
  localparam logic [3:0] BCD_MAX   = 4'd9;

endpackage

// File: rtl/score_counter_inc.sv
// Combinational two-digit BCD increment with overflow to 10/0 and saturation.
import score_counter_pkg::*;

module bcd_score_inc (
  input  logic [3:0] score_1,
  input  logic [3:0] score_0,
  output logic [3:0] next_1,
  output logic [3:0] next_0
);

  logic sat;
  logic ones;
  logic tens;
  logic ovf;

  assign sat  = (score_1 == SCORE_OVF);
  assign ones = !sat && (score_0 < BCD_MAX);
  assign tens = !sat && !ones && (score_1 < BCD_MAX);
  assign ovf  = !sat && !ones && !tens;

  always_comb begin
    next_1 = score_1;
    next_0 = score_0;
    unique case (1'b1)
      sat: ;
      ones: next_0 = score_0 + 4'd1;
      tens: begin
        next_0 = 4'd0;
        next_1 = score_1 + 4'd1;
      end
      ovf: begin
        next_0 = 4'd0;
        next_1 = SCORE_OVF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/score_counter.sv
// Live BCD score tracker: start/point/death FSM feeding the score-record stage.
import score_counter_pkg::*;

module score_counter #(
  parameter logic [31:0] DEAD_HOLD = 32'd50_000_000,
  parameter int          HOLD_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       point_evt,
  input  logic       die_evt,
  output logic [3:0] score_0,
  output logic [3:0] score_1,
  output logic       slime_die,
  output logic       playing
);

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(DEAD_HOLD - 32'd1);

  state_t            state;
  logic [HOLD_W-1:0] hold;
  logic              point_q;
  logic              die_q;
  logic              point_rise;
  logic              die_rise;
  logic [3:0]        inc_1;
  logic [3:0]        inc_0;

  assign point_rise = point_evt & ~point_q;
  assign die_rise   = die_evt & ~die_q;

  bcd_score_inc u_inc (
    .score_1 (score_1),
    .score_0 (score_0),
    .next_1  (inc_1),
    .next_0  (inc_0)
  );

  // Edge registers reset high so a level already up at release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      point_q   <= 1'b1;
      die_q     <= 1'b1;
      score_0   <= 4'd0;
      score_1   <= 4'd0;
      slime_die <= 1'b0;
      playing   <= 1'b0;
    end else begin
      point_q   <= point_evt;
      die_q     <= die_evt;
      slime_die <= 1'b0;
      unique case (state)
        IDLE: begin
          if (game_start) begin
            state   <= PLAY;
            playing <= 1'b1;
            score_0 <= 4'd0;
            score_1 <= 4'd0;
          end
        end
        PLAY: begin
          if (die_rise) begin
            state     <= DEAD;
            playing   <= 1'b0;
            slime_die <= 1'b1;
            hold      <= '0;
          end else if (point_rise) begin
            score_0 <= inc_0;
            score_1 <= inc_1;
          end
        end
        DEAD: begin
          if (hold == HOLD_LAST) begin
            state <= IDLE;
            hold  <= '0;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          playing <= 1'b0;
          hold    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Directed self-checking bench for score_counter with a short DEAD hold.
module tb_score_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_start;
  logic       point_evt;
  logic       die_evt;
  logic [3:0] score_0;
  logic [3:0] score_1;
  logic       slime_die;
  logic       playing;

  int checks = 0;
  int errors = 0;

  score_counter #(
    .DEAD_HOLD (32'd4),
    .HOLD_W    (26)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .game_start (game_start),
    .point_evt  (point_evt),
    .die_evt    (die_evt),
    .score_0    (score_0),
    .score_1    (score_1),
    .slime_die  (slime_die),
    .playing    (playing)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_point(input int n);
    for (int i = 0; i < n; i++) begin
      point_evt = 1'b1;
      step(1);
      point_evt = 1'b0;
      step(1);
    end
  endtask

  task automatic start_game();
    step(6);
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    checks++;
    if (playing !== 1'b1 || score_1 !== 4'd0 || score_0 !== 4'd0) begin
      errors++;
      $display("FAIL start: play=%b sc=%0d/%0d want 1 0/0",
               playing, score_1, score_0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    game_start = 1'b0;
    point_evt = 1'b0;
    die_evt = 1'b0;
    step(3);
    checks++;
    if (score_1 !== 4'd0 || score_0 !== 4'd0 ||
        slime_die !== 1'b0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL reset: sc=%0d/%0d die=%b play=%b want 0/0 0 0",
               score_1, score_0, slime_die, playing);
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_basic_run();
    start_game();
    pulse_point(12);
    checks++;
    if (score_1 !== 4'd1 || score_0 !== 4'd2) begin
      errors++;
      $display("FAIL basic_score: got %0d/%0d want 1/2", score_1, score_0);
    end
    die_evt = 1'b1;
    step(1);
    checks++;
    if (slime_die !== 1'b1 || score_1 !== 4'd1 ||
        score_0 !== 4'd2 || playing !== 1'b0) begin
      errors++;
      $display("FAIL basic_die: die=%b sc=%0d/%0d play=%b want 1 1/2 0",
               slime_die, score_1, score_0, playing);
    end
    die_evt = 1'b0;
    step(1);
    checks++;
    if (slime_die !== 1'b0) begin
      errors++;
      $display("FAIL basic_strobe_len: die=%b want 0", slime_die);
    end
  endtask

  task automatic test_held_point();
    start_game();
    point_evt = 1'b1;
    step(20);
    checks++;
    if (score_1 !== 4'd0 || score_0 !== 4'd1) begin
      errors++;
      $display("FAIL held_point: got %0d/%0d want 0/1", score_1, score_0);
    end
    point_evt = 1'b0;
    step(2);
    pulse_point(1);
    checks++;
    if (score_1 !== 4'd0 || score_0 !== 4'd2) begin
      errors++;
      $display("FAIL reraise: got %0d/%0d want 0/2", score_1, score_0);
    end
    die_evt = 1'b1;
    step(1);
    die_evt = 1'b0;
  endtask

  task automatic test_overflow();
    start_game();
    pulse_point(99);
    checks++;
    if (score_1 !== 4'd9 || score_0 !== 4'd9) begin
      errors++;
      $display("FAIL ovf_99: got %0d/%0d want 9/9", score_1, score_0);
    end
    pulse_point(1);
    checks++;
    if (score_1 !== 4'd10 || score_0 !== 4'd0) begin
      errors++;
      $display("FAIL ovf_100: got %0d/%0d want 10/0", score_1, score_0);
    end
    pulse_point(1);
    checks++;
    if (score_1 !== 4'd10 || score_0 !== 4'd0) begin
      errors++;
      $display("FAIL ovf_sat: got %0d/%0d want 10/0", score_1, score_0);
    end
    die_evt = 1'b1;
    step(1);
    die_evt = 1'b0;
    checks++;
    if (slime_die !== 1'b1 || score_1 !== 4'd10 || score_0 !== 4'd0) begin
      errors++;
      $display("FAIL ovf_die: die=%b sc=%0d/%0d want 1 10/0",
               slime_die, score_1, score_0);
    end
  endtask

  task automatic test_simultaneous();
    start_game();
    pulse_point(5);
    point_evt = 1'b1;
    die_evt = 1'b1;
    step(1);
    checks++;
    if (slime_die !== 1'b1 || score_1 !== 4'd0 || score_0 !== 4'd5) begin
      errors++;
      $display("FAIL simul_die: die=%b sc=%0d/%0d want 1 0/5",
               slime_die, score_1, score_0);
    end
    point_evt = 1'b0;
    die_evt = 1'b0;
    step(2);
    checks++;
    if (score_1 !== 4'd0 || score_0 !== 4'd5) begin
      errors++;
      $display("FAIL simul_hold: got %0d/%0d want 0/5", score_1, score_0);
    end
  endtask

  task automatic test_dead_hold();
    int strobes;
    start_game();
    pulse_point(3);
    die_evt = 1'b1;
    step(1);
    die_evt = 1'b0;
    strobes = 0;
    game_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (slime_die) strobes++;
    end
    checks++;
    if (playing !== 1'b0 || score_1 !== 4'd0 || score_0 !== 4'd3 ||
        strobes != 0) begin
      errors++;
      $display("FAIL dead_ignore: play=%b sc=%0d/%0d strobes=%0d want 0 0/3 0",
               playing, score_1, score_0, strobes);
    end
    step(1);
    game_start = 1'b0;
    checks++;
    if (playing !== 1'b1 || score_1 !== 4'd0 || score_0 !== 4'd0) begin
      errors++;
      $display("FAIL dead_restart: play=%b sc=%0d/%0d want 1 0/0",
               playing, score_1, score_0);
    end
    die_evt = 1'b1;
    step(1);
    die_evt = 1'b0;
  endtask

  task automatic test_async_reset();
    int strobes;
    start_game();
    pulse_point(37);
    checks++;
    if (score_1 !== 4'd3 || score_0 !== 4'd7) begin
      errors++;
      $display("FAIL ar_pre: got %0d/%0d want 3/7", score_1, score_0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    die_evt = 1'b1;
    #1;
    checks++;
    if (score_1 !== 4'd0 || score_0 !== 4'd0 ||
        slime_die !== 1'b0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL ar_now: sc=%0d/%0d die=%b play=%b want 0/0 0 0",
               score_1, score_0, slime_die, playing);
    end
    step(2);
    rst = 1'b0;
    strobes = 0;
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    if (slime_die) strobes++;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (slime_die) strobes++;
    end
    checks++;
    if (strobes != 0 || playing !== 1'b1) begin
      errors++;
      $display("FAIL ar_release: strobes=%0d play=%b want 0 1",
               strobes, playing);
    end
    die_evt = 1'b0;
    step(1);
    die_evt = 1'b1;
    step(1);
    die_evt = 1'b0;
    checks++;
    if (slime_die !== 1'b1) begin
      errors++;
      $display("FAIL ar_die_after: die=%b want 1", slime_die);
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_held_point();
    test_overflow();
    test_simultaneous();
    test_dead_hold();
    test_async_reset();
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
